// File: rtl/div_clk_monitor.sv
// Measures a divided clock in the Clk domain: period and high-phase length in Clk cycles,
// with period tolerance checking, lock qualification and stall (timeout) detection.
module div_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);

    state_t           state, state_n;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, hi_cap, diff;
    logic [3:0]       good_cnt, good_inc;
    logic             in_tol, stall;

    logic [CNT_W-1:0] period_n, high_n;
    logic [3:0]       good_n;
    logic             meas_n, err_n, locked_n, timeout_n;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    // Unsigned distance from the expected period; never wraps.
    assign diff     = (cnt >= EXP_V) ? (cnt - EXP_V) : (EXP_V - cnt);
    assign in_tol   = (diff <= TOL_V);
    assign good_inc = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
    assign stall    = (cnt == TO_V) && !rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            cnt    <= '0;
            hi_cap <= '0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
            if (rise)
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (fall)
                hi_cap <= cnt;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (rise) state_n = ARMED;
            ARMED, LOCKED: begin
                if (rise) begin
                    if (!in_tol)
                        state_n = ARMED;
                    else if (good_inc >= LOCK_V)
                        state_n = LOCKED;
                end else if (stall) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        meas_n    = 1'b0;
        err_n     = 1'b0;
        good_n    = good_cnt;
        locked_n  = locked;
        timeout_n = timeout;
        period_n  = period;
        high_n    = high_time;
        unique case (state)
            IDLE: begin
                // The first edge after reset or a stall only arms; the interval before it is not a period.
                if (rise) begin
                    timeout_n = 1'b0;
                    good_n    = '0;
                end
            end
            ARMED, LOCKED: begin
                if (rise) begin
                    meas_n   = 1'b1;
                    period_n = cnt;
                    high_n   = hi_cap;
                    if (in_tol) begin
                        good_n = good_inc;
                        if (good_inc >= LOCK_V)
                            locked_n = 1'b1;
                    end else begin
                        err_n    = 1'b1;
                        good_n   = '0;
                        locked_n = 1'b0;
                    end
                end else if (stall) begin
                    timeout_n = 1'b1;
                    locked_n  = 1'b0;
                    good_n    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            good_cnt   <= '0;
        end else begin
            period     <= period_n;
            high_time  <= high_n;
            meas_valid <= meas_n;
            period_err <= err_n;
            locked     <= locked_n;
            timeout    <= timeout_n;
            good_cnt   <= good_n;
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench: two monitor instances (TOL=0 and TOL=1) share one stimulus; a reference
// model queues the expected measurement at every generated rising edge.
module tb_div_clk_monitor;

    localparam int EXP  = 5;
    localparam int LOCK = 4;

    typedef struct {
        int p;
        int h;
        bit err;
        bit lk;
    } exp_t;

    logic       clk, rst_n, sig_in;
    logic [7:0] period0, high0, period1, high1;
    logic       mv0, lk0, pe0, to0, mv1, lk1, pe1, to1;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q0[$];
    exp_t q1[$];
    bit   armed[2];
    int   good[2];
    int   prev_p, prev_h;

    div_clk_monitor dut0 (
        .Clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .period(period0), .high_time(high0), .meas_valid(mv0),
        .locked(lk0), .period_err(pe0), .timeout(to0)
    );

    div_clk_monitor #(.TOL(1)) dut1 (
        .Clk(clk), .rst_n(rst_n), .sig_in(sig_in),
        .period(period1), .high_time(high1), .meas_valid(mv1),
        .locked(lk1), .period_err(pe1), .timeout(to1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference behaviour at each rising edge of sig_in: arm, or close the previous period.
    task automatic model_rise();
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int   d;
            if (!armed[i]) begin
                armed[i] = 1'b1;
                good[i]  = 0;
            end else begin
                d     = (prev_p > EXP) ? prev_p - EXP : EXP - prev_p;
                e.p   = prev_p;
                e.h   = prev_h;
                e.err = (d > i);
                if (e.err)
                    good[i] = 0;
                else if (good[i] < 15)
                    good[i]++;
                e.lk = !e.err && (good[i] >= LOCK);
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic drive_cycles(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2 sig_in = v;
        end
    endtask

    task automatic gen_period(input int h, input int l);
        model_rise();
        drive_cycles(1'b1, h);
        drive_cycles(1'b0, l);
        prev_h = h;
        prev_p = h + l;
    endtask

    task automatic mon(input int i, input logic mv, input logic pe, input logic lk,
                       input logic [7:0] p, input logic [7:0] h);
        exp_t e;
        int   qs;
        if (pe)
            check($sformatf("err_with_meas%0d", i), int'(mv), 1);
        if (mv) begin
            qs = (i == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                check($sformatf("meas_expected%0d", i), qs, 1);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("period%0d", i), int'(p), e.p);
                check($sformatf("high_time%0d", i), int'(h), e.h);
                check($sformatf("period_err%0d", i), int'(pe), int'(e.err));
                check($sformatf("locked%0d", i), int'(lk), int'(e.lk));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, mv0, pe0, lk0, period0, high0);
            mon(1, mv1, pe1, lk1, period1, high1);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, int'(period0), 0);
        check({tag, "_high"}, int'(high0), 0);
        check({tag, "_mv"}, int'(mv0), 0);
        check({tag, "_locked"}, int'(lk0), 0);
        check({tag, "_err"}, int'(pe0), 0);
        check({tag, "_timeout"}, int'(to0), 0);
        check({tag, "_locked1"}, int'(lk1), 0);
        check({tag, "_timeout1"}, int'(to1), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        prev_p = 0;
        prev_h = 0;
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b0;
            good[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        #1 rst_n = 1'b1;
        drive_cycles(1'b0, 3);

        // Steady 3/2 waveform: arm, then lock on the fourth measurement.
        repeat (6) gen_period(3, 2);

        // One long period, then recovery.
        gen_period(3, 4);
        repeat (5) gen_period(3, 2);

        // Periods 4, 6, 5, 4, 3 (only the TOL=1 instance accepts the first four).
        gen_period(2, 2);
        gen_period(3, 3);
        gen_period(3, 2);
        gen_period(2, 2);
        gen_period(2, 1);
        repeat (5) gen_period(3, 2);

        // Stall: one last rise, then sig_in held low until timeout.
        model_rise();
        @(posedge clk);
        #2 sig_in = 1'b1;
        for (int n = 1; n <= 258; n++) begin
            @(posedge clk);
            if (n == 3) #2 sig_in = 1'b0;
            if (n == 257) begin
                @(negedge clk);
                check("pre_timeout0", int'(to0), 0);
                check("pre_timeout1", int'(to1), 0);
                check("pre_locked0", int'(lk0), 1);
            end
            if (n == 258) begin
                @(negedge clk);
                check("timeout0", int'(to0), 1);
                check("timeout1", int'(to1), 1);
                check("timeout_locked0", int'(lk0), 0);
                check("timeout_locked1", int'(lk1), 0);
            end
        end
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        gen_period(3, 2);
        check("timeout_clear0", int'(to0), 0);
        check("timeout_clear1", int'(to1), 0);
        repeat (6) gen_period(3, 2);

        // Reset while locked, inside the high phase.
        model_rise();
        @(posedge clk);
        #2 sig_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("locked_before_reset", int'(lk0), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        sig_in   = 1'b0;
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        good[0]  = 0;
        good[1]  = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        drive_cycles(1'b0, 3);
        repeat (3) gen_period(3, 2);

        // Sub-cycle glitch inside the low phase must not register as a rise.
        model_rise();
        drive_cycles(1'b1, 3);
        @(posedge clk);
        #2 sig_in = 1'b0;
        #2 sig_in = 1'b1;
        #1 sig_in = 1'b0;
        drive_cycles(1'b0, 1);
        prev_h = 3;
        prev_p = 5;
        repeat (2) gen_period(3, 2);

        drive_cycles(1'b0, 4);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
